// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin front end that shares one combinational 4-bit ALU among NREQ requesters.
// Latency: accept at edge T, masked result captured at T+1, rsp_valid held until handshake; 3 cycles/op minimum.
// Backpressure: rsp_valid & !rsp_ready freezes rsp_* and blocks every new grant until the handshake.
//
// Ports: clk/rst_n (async active-low); req_valid/req_ready plus packed req_opcode/req_a/req_b
// (requester i at [4i+3:4i]); alu_opcode/alu_a/alu_b registered to the ALU, alu_x/alu_y back from it;
// rsp_valid/rsp_ready with rsp_id/rsp_x/rsp_y; busy = FSM not idle.
// Optional: define ALU_RR_GNT_CNT_EN to add gnt_cnt[8*NREQ-1:0], per-requester saturating accept counters.
module alu_rr_scheduler #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_opcode,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   output logic [3:0]        alu_opcode,
   output logic [3:0]        alu_a,
   output logic [3:0]        alu_b,
   input  logic [3:0]        alu_x,
   input  logic [3:0]        alu_y,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [3:0]        rsp_x,
   output logic [3:0]        rsp_y,
`ifdef ALU_RR_GNT_CNT_EN
   output logic [8*NREQ-1:0] gnt_cnt,
`endif
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state, state_nxt;
   logic [IDW-1:0]  last_grant;
   logic [IDW-1:0]  gnt_idx;
   logic [NREQ-1:0] gnt_oh;
   logic            gnt_any;
   logic [3:0]      sel_op, sel_a, sel_b;
   logic [3:0]      mask_x, mask_y;

   // Round-robin pick: first asserted request searching upward from last_grant+1 with wrap.
   always_comb begin : rr_pick
      int idx;
      idx     = 0;
      gnt_oh  = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(last_grant) + 1 + k) % NREQ;
         if (!gnt_any && req_valid[idx]) begin
            gnt_any     = 1'b1;
            gnt_oh[idx] = 1'b1;
            gnt_idx     = IDW'(idx);
         end
      end
   end

   // One-hot mux of the winner's opcode and operands.
   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_oh[i]) begin
            sel_op = req_opcode[4*i +: 4];
            sel_a  = req_a[4*i +: 4];
            sel_b  = req_b[4*i +: 4];
         end
      end
   end

   // The ALU leaves bits it does not drive stale; force them to defined values per opcode class.
   always_comb begin
      mask_x = alu_x;
      mask_y = alu_y;
      case (alu_opcode)
         4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9: begin
            mask_x = {3'b000, alu_x[0]};
            mask_y = 4'h0;
         end
         4'd3, 4'd4, 4'd5, 4'd11, 4'd15: begin
            mask_y = 4'h0;
         end
         4'd10: begin
            mask_y = {3'b000, alu_y[0]};
         end
         default: ; // 12, 13, 14 drive both nibbles
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            // Gated by rst_n so req_ready reads zero while reset is held.
            req_ready = rst_n ? gnt_oh : '0;
            if (gnt_any) state_nxt = EXEC;
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_x      <= '0;
         rsp_y      <= '0;
         // Pointer at the last index so requester 0 wins first after reset.
         last_grant <= IDW'(NREQ - 1);
      end else begin
         case (state)
            IDLE: if (gnt_any) begin
               alu_opcode <= sel_op;
               alu_a      <= sel_a;
               alu_b      <= sel_b;
               rsp_id     <= gnt_idx;
               last_grant <= gnt_idx;
            end
            EXEC: begin
               rsp_x     <= mask_x;
               rsp_y     <= mask_y;
               rsp_valid <= 1'b1;
            end
            RESP:    if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef ALU_RR_GNT_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_cnt <= '0;
      end else if (state == IDLE) begin
         for (int i = 0; i < NREQ; i++) begin
            if (gnt_oh[i] && gnt_cnt[8*i +: 8] != 8'hFF)
               gnt_cnt[8*i +: 8] <= gnt_cnt[8*i +: 8] + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed bench for alu_rr_scheduler with a behavioural ALU that leaves stale bits.
// Latency: checks exact cycle of grant, ALU register load and response.
// Backpressure: holds rsp_ready low with other requests pending and checks freeze.
module tb_alu_rr_scheduler;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_opcode, req_a, req_b;
   logic [3:0]        alu_opcode, alu_a, alu_b, alu_x, alu_y;
   logic              rsp_valid, rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [3:0]        rsp_x, rsp_y;
   logic              busy;
`ifdef ALU_RR_GNT_CNT_EN
   logic [8*NREQ-1:0] gnt_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_x(alu_x), .alu_y(alu_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
`ifdef ALU_RR_GNT_CNT_EN
      .gnt_cnt(gnt_cnt),
`endif
      .busy(busy)
   );

   // Shared ALU model; undriven result bits carry deliberate garbage.
   logic       bitv;
   logic [4:0] sum;
   logic [7:0] prod;
   always_comb begin
      bitv  = 1'b0;
      sum   = {1'b0, alu_a} + {1'b0, alu_b};
      prod  = {4'h0, alu_a} * {4'h0, alu_b};
      alu_x = 4'h0;
      alu_y = 4'h0;
      case (alu_opcode)
         4'd0:  bitv = (alu_a == alu_b);
         4'd1:  bitv = (alu_a != alu_b);
         4'd2:  bitv = (alu_a <  alu_b);
         4'd6:  bitv = (alu_a >  alu_b);
         4'd7:  bitv = (alu_a >= alu_b);
         4'd8:  bitv = ^alu_a;
         4'd9:  bitv = |alu_a;
         default: bitv = 1'b0;
      endcase
      case (alu_opcode)
         4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9: begin alu_x = {3'b101, bitv}; alu_y = 4'hA; end
         4'd3:  begin alu_x = alu_a & alu_b; alu_y = 4'h5; end
         4'd4:  begin alu_x = alu_a | alu_b; alu_y = 4'h5; end
         4'd5:  begin alu_x = alu_a ^ alu_b; alu_y = 4'h5; end
         4'd11: begin alu_x = alu_a - alu_b; alu_y = 4'h5; end
         4'd15: begin alu_x = ~alu_a;        alu_y = 4'h5; end
         4'd10: begin alu_x = sum[3:0];      alu_y = {3'b111, sum[4]}; end
         4'd12: begin alu_x = prod[3:0];     alu_y = prod[7:4]; end
         4'd13: begin alu_x = alu_b;         alu_y = alu_a; end
         default: begin alu_x = ~alu_b;      alu_y = ~alu_a; end
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issue one op from a lone requester; entered and left at a negedge with the FSM idle.
   task automatic do_op(input int id, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ex, input logic [3:0] ey, input int hold);
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_opcode[4*id +: 4] = op;
      req_a[4*id +: 4] = a;
      req_b[4*id +: 4] = b;
      #1 chk("grant", 32'(req_ready), 32'd1 << id);
      @(negedge clk);
      req_valid = '0;
      chk("exec_busy", 32'(busy), 32'd1);
      chk("exec_alu", 32'({alu_opcode, alu_a, alu_b}), 32'({op, a, b}));
      chk("exec_rvld", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("rsp_vld", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(id));
      chk("rsp_x", 32'(rsp_x), 32'(ex));
      chk("rsp_y", 32'(rsp_y), 32'(ey));
      for (int h = 0; h < hold; h++) begin
         req_valid = '0;
         req_valid[(id + 1) % NREQ] = 1'b1;
         @(negedge clk);
         chk("hold_vld", 32'(rsp_valid), 32'd1);
         chk("hold_rsp", 32'({rsp_id, rsp_x, rsp_y}), 32'({2'(id), ex, ey}));
         chk("hold_rdy", 32'(req_ready), 32'd0);
         chk("hold_busy", 32'(busy), 32'd1);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("done_vld", 32'(rsp_valid), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int gcyc[8], grdy[8], rid[8], rxy[8];
      int ng, nr, seen;
      int exp_x[4];
      exp_x[0] = 3; exp_x[1] = 6; exp_x[2] = 9; exp_x[3] = 12;

      rst_n = 1'b0;
      req_valid = 4'hF;
      req_opcode = '0; req_a = '0; req_b = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
      chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_x, rsp_y}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
`ifdef ALU_RR_GNT_CNT_EN
      chk("rst_cnt", gnt_cnt, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = '0;

      // Single requests: op 10 carry, masking classes, passthrough of y.
      do_op(2, 4'd10, 4'hF, 4'h1, 4'h0, 4'h1, 0);
      do_op(1, 4'd12, 4'h3, 4'h4, 4'hC, 4'h0, 0);
      do_op(3, 4'd6,  4'h5, 4'h2, 4'h1, 4'h0, 0);
      do_op(0, 4'd4,  4'h5, 4'h2, 4'h7, 4'h0, 0);
      do_op(3, 4'd0,  4'h3, 4'h3, 4'h1, 4'h0, 0);
      do_op(2, 4'd13, 4'h9, 4'h6, 4'h6, 4'h9, 0);
      // Backpressure for 5 cycles, then an immediate grant in IDLE.
      do_op(0, 4'd5,  4'hC, 4'hA, 4'h6, 4'h0, 5);
      do_op(1, 4'd14, 4'h3, 4'h5, 4'hA, 4'hC, 0);

      // Reset during EXEC: op discarded, outputs clear asynchronously.
      req_valid = 4'b0100;
      req_opcode[11:8] = 4'd13; req_a[11:8] = 4'h9; req_b[11:8] = 4'h6;
      #1 chk("mid_grant", 32'(req_ready), 32'h4);
      @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
      chk("mid_rst_rsp", 32'({rsp_valid, rsp_id, rsp_x, rsp_y}), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) seen = 1;
      end
      chk("mid_no_rsp", 32'(seen), 32'd0);
      rst_n = 1'b1;
      req_valid = '0;

      // All four requesting continuously: grants 0,1,2,3,0,1 every 3 cycles.
      for (int i = 0; i < 8; i++) begin gcyc[i] = -1; grdy[i] = -1; rid[i] = -1; rxy[i] = -1; end
      ng = 0; nr = 0;
      for (int i = 0; i < NREQ; i++) begin
         req_opcode[4*i +: 4] = 4'd12;
         req_a[4*i +: 4] = 4'(i + 1);
         req_b[4*i +: 4] = 4'd3;
      end
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int c = 0; c < 18; c++) begin
         #1;
         if (req_ready != '0 && ng < 8) begin gcyc[ng] = c; grdy[ng] = int'(req_ready); ng++; end
         if (rsp_valid && nr < 8) begin rid[nr] = int'(rsp_id); rxy[nr] = int'({rsp_y, rsp_x}); nr++; end
         if (c < 17) @(negedge clk);
      end
      req_valid = '0;
      chk("rr_ngrants", 32'(ng), 32'd6);
      chk("rr_nrsp", 32'(nr), 32'd6);
      for (int k = 0; k < 6; k++) begin
         chk("rr_gnt_oh", 32'(grdy[k]), 32'd1 << (k % 4));
         chk("rr_gnt_cyc", 32'(gcyc[k]), 32'(3 * k));
         chk("rr_rsp_id", 32'(rid[k]), 32'(k % 4));
         chk("rr_rsp_xy", 32'(rxy[k]), 32'(exp_x[k % 4]));
      end
      @(negedge clk);
      chk("rr_idle", 32'(busy), 32'd0);

`ifdef ALU_RR_GNT_CNT_EN
      // Since the last reset: req0 x2, req1 x2, req2 x1, req3 x1; then 300 more to req1.
      req_valid = 4'b0010;
      repeat (900) @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      chk("cnt_sat", 32'(gnt_cnt[15:8]), 32'd255);
      chk("cnt_all", gnt_cnt, {8'd1, 8'd1, 8'd255, 8'd2});
`endif
      rsp_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
